// File: rtl/mmio_uart_tx_if.sv
// Data-memory store/load bus snooped by the MMIO UART transmitter.
// master = core side driving addr/din/WE, slave = peripheral returning rdata/hit.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic        WE;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, din, WE, input rdata, hit);
  modport slave  (input addr, din, WE, output rdata, hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: FIFO-buffered 8N1 serialiser with a status word; tx falls one cycle after a push into an idle unit.
// No backpressure on the store path: pushes into a full FIFO are dropped and flagged as sticky overflow.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0104
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam int             PW        = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]    DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            overflow;
  logic [7:0]      shift, shift_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [BW-1:0]   baud_cnt, baud_nxt;
  logic            tx_nxt, pop;
  logic            tx_hit, stat_hit, empty, full, push, ovf_set, ovf_clr, baud_done;
  logic            din_unused;

  assign tx_hit    = (bus.addr == TX_ADDR);
  assign stat_hit  = (bus.addr == STAT_ADDR);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  // push decision uses the pre-edge full flag, so a same-edge pop never frees room for it
  assign push      = bus.WE && tx_hit && !full;
  assign ovf_set   = bus.WE && tx_hit && full;
  assign ovf_clr   = bus.WE && stat_hit && bus.din[3];
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign din_unused = ^bus.din[31:8];

  assign bus.hit   = tx_hit || stat_hit;
  assign bus.rdata = stat_hit ? {28'b0, overflow, (state != IDLE), full, empty} : 32'b0;
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    baud_nxt  = baud_cnt + 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt = DATA;
          tx_nxt    = shift[0];
          bit_nxt   = 3'd0;
          baud_nxt  = '0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
            bit_nxt   = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          // chain straight into the next start bit when data is waiting
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        baud_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_nxt;
      baud_cnt <= baud_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a frame monitor pops expected bytes from a scoreboard queue
// and compares whole 40-sample frames; directed steps check status, latency, overflow and reset abort.
module tb_mmio_uart_tx;
  localparam int          CPB  = 4;
  localparam int          DEP  = 8;
  localparam logic [31:0] TXA  = 32'h0000_0100;
  localparam logic [31:0] STA  = 32'h0000_0104;
  localparam logic [31:0] OTH  = 32'h0000_0108;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_abort;
  logic [7:0] exp_q[$];
  int   frame_starts[$];

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .TX_ADDR(TXA), .STAT_ADDR(STA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [39:0] obs, exp;
    logic [7:0]  b;
    logic        aborted;
    int          idx;
    forever begin
      @(negedge clk);
      if (!mon_abort && reset === 1'b1 && tx === 1'b0) begin
        frame_starts.push_back(cyc);
        check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        aborted = 1'b0;
        for (int i = 0; i < 40; i++) begin
          if (i > 0) @(negedge clk);
          if (mon_abort) begin
            aborted = 1'b1;
            break;
          end
          obs[i] = tx;
          idx = i / CPB;
          exp[i] = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
        end
        if (!aborted) check("frame_bits", 64'(obs), 64'(exp));
      end
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.WE   = 1'b1;
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.addr = 32'h0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] r, output logic h);
    bus.addr = a;
    bus.WE   = 1'b0;
    #1;
    r = bus.rdata;
    h = bus.hit;
    bus.addr = 32'h0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        h;
    int          n;
    int          lows;

    reset = 1'b0; bus.addr = 32'h0; bus.din = 32'h0; bus.WE = 1'b0; mon_abort = 1'b1;
    fork
      monitor();
    join_none

    // 1: reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_abort = 1'b0;
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    peek(STA, r, h);
    check("rst_status", 64'(r), 64'h1);
    check("rst_stat_hit", 64'(h), 64'd1);

    // 2: single frame, latency and length
    exp_q.push_back(8'h55);
    store(TXA, 32'hFFFF_FF55);
    check("lat_tx_still_high", 64'(tx), 64'd1);
    check("lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_tx_low", 64'(tx), 64'd0);
    wait_idle(100, n);
    check("frame_len_busy", 64'(n), 64'd40);

    // 3: back-to-back frames
    frame_starts.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    store(TXA, 32'hA1);
    store(TXA, 32'hB2);
    store(TXA, 32'hC3);
    wait_idle(300, n);
    check("b2b_idle_in_time", 64'(n < 300), 64'd1);
    check("b2b_frames", 64'(frame_starts.size()), 64'd3);
    if (frame_starts.size() == 3) begin
      check("b2b_gap01", 64'(frame_starts[1] - frame_starts[0]), 64'd40);
      check("b2b_gap12", 64'(frame_starts[2] - frame_starts[1]), 64'd40);
    end
    check("b2b_q_drained", 64'(exp_q.size()), 64'd0);

    // 4: overflow while the first frame is on the wire
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h10 + i));
    store(TXA, 32'h10);
    @(negedge clk);
    for (int i = 1; i < 10; i++) store(TXA, 32'(8'h10 + i));
    peek(STA, r, h);
    check("ovf_status", 64'(r), 64'hE);
    store(STA, 32'h8);
    peek(STA, r, h);
    check("ovf_cleared", 64'(r), 64'h6);
    wait_idle(500, n);
    check("ovf_idle_in_time", 64'(n < 500), 64'd1);
    check("ovf_q_drained", 64'(exp_q.size()), 64'd0);
    peek(STA, r, h);
    check("ovf_final_status", 64'(r), 64'h1);

    // 5: reset during DATA of the first of three queued frames
    exp_q.push_back(8'h3C); exp_q.push_back(8'h4D); exp_q.push_back(8'h5E);
    store(TXA, 32'h3C);
    store(TXA, 32'h4D);
    store(TXA, 32'h5E);
    repeat (8) @(negedge clk);
    mon_abort = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    mon_abort = 1'b0;
    exp_q.delete();
    peek(STA, r, h);
    check("abort_status", 64'(r), 64'h1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("abort_no_frames", 64'(lows), 64'd0);

    // 6: non-matching address
    bus.addr = OTH; bus.din = 32'h5A; bus.WE = 1'b1;
    #1;
    check("oth_store_hit", 64'(bus.hit), 64'd0);
    check("oth_store_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    bus.WE = 1'b0;
    #1;
    check("oth_load_hit", 64'(bus.hit), 64'd0);
    check("oth_load_rdata", 64'(bus.rdata), 64'd0);
    bus.addr = 32'h0;
    repeat (3) @(negedge clk);
    check("oth_tx", 64'(tx), 64'd1);
    check("oth_busy", 64'(busy), 64'd0);
    peek(STA, r, h);
    check("oth_status", 64'(r), 64'h1);
    check("oth_stat_hit", 64'(h), 64'd1);
    peek(TXA, r, h);
    check("txaddr_hit", 64'(h), 64'd1);
    check("txaddr_rdata", 64'(r), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-memory bus, directly downstream of the core's store path.
- Snoops the same addr/din/WE signals that drive data memory.
- Buffers store bytes written to the TX data address in a small FIFO and serialises them 8N1, LSB first, on a single tx line.
- Exposes a status word the core reads back through the load path. The top level muxes rdata in place of the data memory output when hit=1.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (minimum 2).
- FIFO_DEPTH, 8, byte entries in the TX FIFO (power of 2, at least 2).
- TX_ADDR, 32'h0000_0100, word address; a store here pushes din[7:0].
- STAT_ADDR, 32'h0000_0104, word address; load returns status, store clears sticky bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- addr  in  32  data bus address (ALU result).
- din  in  32  store data (rs2 value).
- WE  in  1  store strobe (MemWrite).
- rdata  out  32  combinational read data for STAT_ADDR; 0 for any other address.
- hit  out  1  combinational; 1 when addr == TX_ADDR or addr == STAT_ADDR.
- tx  out  1  registered serial output; idle high.
- busy  out  1  1 when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, tx=1, FIFO empty (read and write pointers 0, count 0), overflow=0, bit and baud counters 0, busy=0.
  - Reset mid-frame aborts the frame: tx=1 after that edge and all queued bytes are discarded.
- Push: at an edge with WE=1, addr==TX_ADDR, !full → din[7:0] is written to the FIFO and count increments. din[31:8] is ignored.
- Overflow: WE=1, addr==TX_ADDR, full → the byte is dropped, overflow is set to 1 (sticky), and FIFO contents are unchanged.
- Push and pop in the same edge: the push condition uses the pre-edge full flag. A push to a full FIFO is rejected even if a pop occurs on that edge. When not full, push and pop both occur and count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- Status word (rdata when addr==STAT_ADDR): bit0=empty, bit1=full, bit2=(state!=IDLE), bit3=overflow, bits[31:4]=0.
- Store to STAT_ADDR with din[3]=1 clears overflow. If an overflow event occurs on the same edge, set wins.
- FSM states:
  - IDLE: tx=1. If !empty, pop the head into the shift register, go to START, and drive tx=0 from this edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles; shift right; after bit 7 go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end, if !empty, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state or bit change.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a push sampled at edge E0 with an empty FIFO and IDLE state → tx falls after edge E1 (one cycle later).
- Non-matching addresses: no state change, rdata=0, hit=0. Loads (WE=0) never alter state.

Test Plan:
1. Reset=0 for 2 cycles, then release → tx=1, busy=0, status read returns 32'h0000_0001.
2. CLKS_PER_BIT=4; store 32'hFFFF_FF55 to TX_ADDR → tx goes low one cycle after the store edge, then shows 1,0,1,0,1,0,1,0 at 4 cycles per bit, then stop 1. The frame lasts 40 cycles and busy falls after the stop bit.
3. Three back-to-back stores 8'hA1, 8'hB2, 8'hC3 → three contiguous 40-cycle frames with no idle cycles between them; bytes appear in order.
4. FIFO_DEPTH=8 with tx stalled mid-frame: store 10 bytes → the first popped byte plus 8 are kept and the 10th is dropped. Status bit3=1 and bit1=1; a store of 32'h8 to STAT_ADDR clears bit3.
5. Assert reset=0 during the DATA state of frame 1 with 3 bytes queued → tx=1 next edge, status=32'h1, no further frames.
6. Store and load to address 32'h0000_0108 → hit=0, rdata=0, FIFO unchanged. A load at STAT_ADDR gives hit=1.
